// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with parametrised framing
module uart_tx_fifo #(
   parameter int CLK_DIV    = 434,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          UART_TX,
   output logic                          UART_GND
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(CLK_DIV);

   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
   localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state, state_n;
   logic [BW-1:0]         baud_cnt, baud_n;
   logic [2:0]            bit_cnt, bit_n;
   logic [DATA_BITS-1:0]  shift, shift_n;
   logic                  par_q, par_n;
   logic                  tx_n;
   logic                  busy_n;
   logic [LW-1:0]         level_n;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0]  head;
   logic                  head_par;
   logic                  push, pop, load, wrap;

   // tx_ready is decoded straight from the level register so a full FIFO
   // refuses a push even when a pop happens on the same edge.
   assign tx_ready = (fifo_level != LEVEL_FULL);
   assign push     = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];
   assign head_par = (PARITY == 1) ? ~(^head) : ^head;
   assign wrap     = (baud_cnt == BAUD_LAST);
   assign level_n  = fifo_level + LW'(push) - LW'(pop);
   assign UART_GND = 1'b0;

   // FIFO storage: written on an accepted handshake, never reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // next-state and next-output decode for the framing FSM
   always_comb begin
      state_n = state;
      baud_n  = wrap ? '0 : baud_cnt + BW'(1);
      bit_n   = bit_cnt;
      shift_n = shift;
      par_n   = par_q;
      tx_n    = UART_TX;
      load    = 1'b0;
      pop     = 1'b0;
      case (state)
         S_IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (fifo_level != '0) begin
               load = 1'b1;
            end
         end
         S_START: begin
            if (wrap) begin
               state_n = S_DATA;
               tx_n    = shift[0];
               bit_n   = '0;
            end
         end
         S_DATA: begin
            if (wrap) begin
               if (bit_cnt == LAST_DATA) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     state_n = S_PARITY;
                     tx_n    = par_q;
                  end else begin
                     state_n = S_STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n   = bit_cnt + 3'd1;
                  shift_n = shift >> 1;
                  tx_n    = shift[1];
               end
            end
         end
         S_PARITY: begin
            if (wrap) begin
               state_n = S_STOP;
               tx_n    = 1'b1;
               bit_n   = '0;
            end
         end
         S_STOP: begin
            if (wrap) begin
               if (bit_cnt == LAST_STOP) begin
                  // a queued character starts immediately: no idle gap
                  if (fifo_level != '0) begin
                     load = 1'b1;
                  end else begin
                     state_n = S_IDLE;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
         end
      endcase
      if (load) begin
         pop     = 1'b1;
         shift_n = head;
         par_n   = head_par;
         bit_n   = '0;
         baud_n  = '0;
         state_n = S_START;
         tx_n    = 1'b0;
      end
      busy_n = (state_n != S_IDLE) || (level_n != '0);
   end

   // state, counters, serial line and FIFO bookkeeping registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         par_q      <= 1'b0;
         UART_TX    <= 1'b1;
         busy       <= 1'b0;
         fifo_level <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_n;
         baud_cnt   <= baud_n;
         bit_cnt    <= bit_n;
         shift      <= shift_n;
         par_q      <= par_n;
         UART_TX    <= tx_n;
         busy       <= busy_n;
         fifo_level <= level_n;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

endmodule
